pixel_write_sink: RTL
=====================

Name: pixel_write_sink

Overview:
- Receiving end of the pixel-plot interface driven by the text/string renderers (x, y, pixelColor per plotted pixel).
- Accepts pixel writes via a valid/ready handshake and buffers them in a small FIFO.
- Clips off-screen coordinates, converts (x,y) to a linear framebuffer address, and issues single-cycle writes to the 1-bit framebuffer when the framebuffer port is not stalled by scan-out.

Parameters:
- H_RES, 640, visible columns; x >= H_RES is off-screen.
- V_RES, 480, visible rows; y >= V_RES is off-screen.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- CNT_W, 16, width of the clipped-pixel counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  producer presents a pixel.
- in_ready  out  1  sink can accept; equals !full.
- in_x  in  11  pixel column.
- in_y  in  11  pixel row.
- in_color  in  1  1 = draw, 0 = erase.
- fb_stall  in  1  framebuffer port busy; no write may issue while high.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- fb_addr  out  ADDR_W  y*H_RES + x.
- fb_wdata  out  1  pixel colour.
- clr_count  in  1  synchronous clear of clipped_count.
- clipped_count  out  CNT_W  saturating count of dropped off-screen pixels.
- idle  out  1  FIFO empty and fb_we low.

Behaviour:
- Reset (reset == 0, async):
  - FIFO pointers and count = 0.
  - fb_we = 0, fb_addr = 0, fb_wdata = 0, clipped_count = 0.
  - in_ready = 1, idle = 1.
  - Reset mid-operation discards all buffered pixels with no partial write.
- Accept: transfer occurs on a posedge with in_valid && in_ready.
  - in_ready = !full only; a pop in the same cycle does not free a slot for a push that cycle.
- Clip at input: a transfer with in_x >= H_RES or in_y >= V_RES completes the handshake but is not pushed.
  - clipped_count += 1, saturating at all-ones.
  - If clr_count coincides with a clip, clear wins and the result is 0.
- Pop condition: FIFO non-empty && !fb_stall.
  - On a pop, register fb_we = 1, fb_addr = y*H_RES + x (full product, truncated to ADDR_W), fb_wdata = color.
  - Otherwise fb_we = 0 next cycle; fb_addr and fb_wdata hold their last value.
- Latency: a pixel accepted at edge E into an empty FIFO with fb_stall low gives fb_we high in the cycle after edge E+1, i.e. 2 clocks.
- Throughput: 1 pixel/clock sustained when fb_stall is low.
- fb_stall asserted: no pops; FIFO fills; in_ready drops when count == DEPTH.
- Simultaneous push and pop on a non-full FIFO: count unchanged; order preserved (strict FIFO).
- Pointer wrap-around at DEPTH is seamless, with no lost or duplicated entries.
- Full: count == DEPTH, pushes blocked. Empty: count == 0, no pop, fb_we stays 0.
- Boundary pixels (639,479) and (0,0) are on-screen and written; addresses 307199 and 0.

Decomposition:
- Shared package vga_pkg:
  - H_RES, V_RES, ADDR_W constants.
  - coord_t (logic [10:0]).
  - pixel_t struct {coord_t x; coord_t y; logic color;}.
- Sub-module pixel_fifo:
  - Parameterised by DEPTH and element type.
  - push/pop/full/empty/count interface, async active-low reset.
- Top level holds the clip logic, address computation, output register and counter.

Test Plan:
- Single pixel (10,2,1), fb_stall = 0 -> exactly one fb_we pulse 2 clocks after accept, fb_addr = 1290, fb_wdata = 1; idle returns to 1.
- Clipping: pixels (640,0), (0,480), (5,5) -> clipped_count = 2, a single write at fb_addr = 3205; pulse clr_count -> clipped_count = 0.
- Backpressure: fb_stall = 1, offer 10 pixels back-to-back -> in_ready drops after 8 accepted; release stall -> 8 writes in order on consecutive cycles, then the remaining 2 accepted and written.
- Wrap and concurrency: stream 50 pixels with random fb_stall -> write sequence matches the accepted on-screen sequence exactly, no duplicates.
- Corners: (639,479,0) then (0,0,1) -> addresses 307199 (wdata 0) then 0 (wdata 1).
- Reset mid-burst: assert reset with 5 entries buffered -> fb_we = 0 immediately, FIFO empty, no further writes after release; a new pixel then follows normal 2-clock latency.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared display geometry and pixel types for the pixel-plot path.
package vga_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a pointer/count scheme. DEPTH must be a power of
// two so the pointers wrap for free. Read data is presented combinationally
// from the head entry.
module pixel_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  T                         wdata_i,
  input  logic                     pop_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard the requests so an overflow/underflow can never corrupt state.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO and discards everything buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Receiving end of the pixel-plot interface: accepts pixels, drops off-screen
// ones (counting them), buffers the rest and issues one framebuffer write per
// pixel whenever the framebuffer port is not stalled by scan-out.
module pixel_write_sink
  import vga_pkg::*;
#(
  parameter int H_RES  = vga_pkg::H_RES,
  parameter int V_RES  = vga_pkg::V_RES,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_x,
  input  logic [10:0]       in_y,
  input  logic              in_color,
  input  logic              fb_stall,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_wdata,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  clipped_count,
  output logic              idle
);

  pixel_t                  in_pix;
  pixel_t                  head_pix;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    xfer, off_screen, push, clip, pop;

  logic                    fb_we_q,    fb_we_d;
  logic [ADDR_W-1:0]       fb_addr_q,  fb_addr_d;
  logic                    fb_wdata_q, fb_wdata_d;
  logic [CNT_W-1:0]        clip_cnt_q, clip_cnt_d;

  assign in_pix     = '{x: in_x, y: in_y, color: in_color};
  // Ready depends only on fullness; a same-cycle pop does not open a slot.
  assign in_ready   = !fifo_full;
  assign xfer       = in_valid && in_ready;
  assign off_screen = (32'(in_x) >= H_RES) || (32'(in_y) >= V_RES);
  assign push       = xfer && !off_screen;
  assign clip       = xfer &&  off_screen;
  assign pop        = !fifo_empty && !fb_stall;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (in_pix),
    .pop_i   (pop),
    .rdata_o (head_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Write-port next state and saturating clip counter (clear beats increment).
  always_comb begin
    fb_we_d    = pop;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (pop) begin
      fb_addr_d  = ADDR_W'(32'(head_pix.y) * 32'(H_RES) + 32'(head_pix.x));
      fb_wdata_d = head_pix.color;
    end
    clip_cnt_d = clip_cnt_q;
    if (clr_count)
      clip_cnt_d = '0;
    else if (clip && (clip_cnt_q != '1))
      clip_cnt_d = clip_cnt_q + CNT_W'(1);
  end

  // Registered framebuffer write port and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_wdata      = fb_wdata_q;
  assign clipped_count = clip_cnt_q;
  assign idle          = (fifo_count == '0) && !fb_we_q;

endmodule
